// File: rtl/video_stream_framer.sv
// Pixel-stream framing stage: 2-entry skid buffer with SOF/last tagging,
// optional offset-binary conversion, SOF resynchronisation and frame counting.
module video_stream_framer #(
    parameter int Height    = 600,
    parameter int Width     = 800,
    parameter int Channels  = 3,
    parameter int DataWidth = 8
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            offset_en_i,
    input  logic                            last_mode_i,
    input  logic                            slave_valid_i,
    output logic                            slave_ready_o,
    input  logic [Channels*DataWidth-1:0]   slave_data_i,
    input  logic                            slave_user_i,
    output logic                            master_valid_o,
    input  logic                            master_ready_i,
    output logic [Channels*DataWidth-1:0]   master_data_o,
    output logic                            master_user_o,
    output logic                            master_last_o,
    output logic [15:0]                     frame_count_o,
    output logic                            resync_o
);

    localparam int PixW = Channels * DataWidth;
    localparam int ColW = (Width > 1) ? $clog2(Width) : 1;
    localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(Width - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(Height - 1);

    // Flipping each channel MSB maps unsigned <-> offset-binary signed.
    function automatic logic [PixW-1:0] offset_convert(input logic [PixW-1:0] pix,
                                                       input logic en);
        logic [PixW-1:0] res;
        res = pix;
        for (int ch = 0; ch < Channels; ch++) begin
            res[ch*DataWidth + DataWidth - 1] = pix[ch*DataWidth + DataWidth - 1] ^ en;
        end
        return res;
    endfunction

    logic [PixW-1:0] head_data_r, tail_data_r;
    logic            head_user_r, head_last_r, tail_user_r, tail_last_r;
    logic [1:0]      count_r;
    logic            ready_r, valid_r;
    logic [ColW-1:0] col_r;
    logic [RowW-1:0] row_r;
    logic            mode_r;
    logic [15:0]     frame_count_r;
    logic            resync_r;

    logic            push_s, pop_s, resync_s, frame_end_s;
    logic            beat_sof_s, beat_mode_s, beat_last_s;
    logic            col_end_s, row_end_s;
    logic [ColW-1:0] eff_col_s, next_col_s;
    logic [RowW-1:0] eff_row_s, next_row_s;
    logic [PixW-1:0] beat_data_s;
    logic [1:0]      count_next_s;

    // Accept/emit handshakes, beat position, tags and next buffer occupancy.
    always_comb begin
        push_s       = slave_valid_i & ready_r;
        pop_s        = valid_r & master_ready_i;
        resync_s     = push_s & slave_user_i & ((col_r != '0) | (row_r != '0));
        eff_col_s    = col_r;
        eff_row_s    = row_r;
        next_col_s   = col_r;
        next_row_s   = row_r;
        count_next_s = count_r;
        if (resync_s) begin
            eff_col_s = '0;
            eff_row_s = '0;
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
        beat_sof_s  = (eff_col_s == '0) & (eff_row_s == '0);
        beat_mode_s = beat_sof_s ? last_mode_i : mode_r;
        col_end_s   = (eff_col_s == ColLast);
        row_end_s   = (eff_row_s == RowLast);
        beat_last_s = col_end_s & (beat_mode_s | row_end_s);
        frame_end_s = push_s & (resync_s | (col_end_s & row_end_s));
        beat_data_s = offset_convert(slave_data_i, offset_en_i);
        if (col_end_s) begin
            next_col_s = '0;
            next_row_s = row_end_s ? '0 : eff_row_s + RowW'(1);
        end else begin
            next_col_s = eff_col_s + ColW'(1);
            next_row_s = eff_row_s;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Skid buffer: the head entry drives master_* directly.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_data_r <= '0;
            tail_data_r <= '0;
            head_user_r <= 1'b0;
            head_last_r <= 1'b0;
            tail_user_r <= 1'b0;
            tail_last_r <= 1'b0;
            count_r     <= 2'd0;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s < 2'd2);
            valid_r <= (count_next_s != 2'd0);
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_data_r <= beat_data_s;
                        head_user_r <= beat_sof_s;
                        head_last_r <= beat_last_s;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_data_r <= beat_data_s;
                        head_user_r <= beat_sof_s;
                        head_last_r <= beat_last_s;
                    end else if (push_s) begin
                        tail_data_r <= beat_data_s;
                        tail_user_r <= beat_sof_s;
                        tail_last_r <= beat_last_s;
                    end else if (pop_s) begin
                        head_user_r <= 1'b0;
                        head_last_r <= 1'b0;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_data_r <= tail_data_r;
                        head_user_r <= tail_user_r;
                        head_last_r <= tail_last_r;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    // Frame position, per-frame mode latch, frame counter and resync pulse.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            col_r         <= '0;
            row_r         <= '0;
            mode_r        <= 1'b0;
            frame_count_r <= 16'd0;
            resync_r      <= 1'b0;
        end else begin
            resync_r <= resync_s;
            if (push_s) begin
                col_r <= next_col_s;
                row_r <= next_row_s;
                if (beat_sof_s) begin
                    mode_r <= last_mode_i;
                end
            end
            if (frame_end_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign slave_ready_o  = ready_r;
    assign master_valid_o = valid_r;
    assign master_data_o  = head_data_r;
    assign master_user_o  = head_user_r;
    assign master_last_o  = head_last_r;
    assign frame_count_o  = frame_count_r;
    assign resync_o       = resync_r;

endmodule

// File: tb/tb_video_stream_framer.sv
// Bench for video_stream_framer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_video_stream_framer;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int C  = 3;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        offset_en = 1'b0;
    logic        last_mode = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_user = 1'b0;
    logic [23:0] s_data = 24'h000000;
    logic        m_ready = 1'b0;
    logic        slave_ready_o, master_valid_o, master_user_o, master_last_o, resync_o;
    logic [23:0] master_data_o;
    logic [15:0] frame_count_o;

    always #5 clk = ~clk;

    video_stream_framer #(.Height(H), .Width(W), .Channels(C), .DataWidth(DW)) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .offset_en_i    (offset_en),
        .last_mode_i    (last_mode),
        .slave_valid_i  (s_valid),
        .slave_ready_o  (slave_ready_o),
        .slave_data_i   (s_data),
        .slave_user_i   (s_user),
        .master_valid_o (master_valid_o),
        .master_ready_i (m_ready),
        .master_data_o  (master_data_o),
        .master_user_o  (master_user_o),
        .master_last_o  (master_last_o),
        .frame_count_o  (frame_count_o),
        .resync_o       (resync_o)
    );

    int checks = 0;
    int passes = 0;
    int fails_printed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            if (fails_printed < 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
            fails_printed++;
        end
    endtask

    // Reference model: pending output beats, linear position within the frame.
    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       q[$];
    int          k_m = 0;
    logic        mode_m = 1'b0;
    logic [15:0] fc_m = 16'd0;
    logic        res_m = 1'b0;
    logic        rdy_m = 1'b0;
    logic        zero_m = 1'b1;

    function automatic logic [23:0] conv(input logic [23:0] d, input logic en);
        logic [23:0] o;
        int          v;
        o = 24'h000000;
        for (int ch = 0; ch < C; ch++) begin
            v = int'((d >> ((C - 1 - ch) * DW)) & 24'h0000FF);
            if (en) v = (v + 128) % 256;
            o[(C-1-ch)*DW +: DW] = v[7:0];
        end
        return o;
    endfunction

    // One clock: predict effect of the current inputs, advance, then compare.
    task automatic tick();
        beat_t b;
        int    r, c;
        logic  acc, emit;
        if (reset_i) begin
            q.delete();
            k_m = 0; mode_m = 1'b0; fc_m = 16'd0; res_m = 1'b0; rdy_m = 1'b0; zero_m = 1'b1;
        end else begin
            acc  = s_valid && rdy_m;
            emit = (q.size() != 0) && m_ready;
            if (emit) void'(q.pop_front());
            res_m = 1'b0;
            if (acc) begin
                if (s_user && k_m != 0) begin
                    res_m = 1'b1;
                    fc_m++;
                    k_m = 0;
                end
                if (k_m == 0) mode_m = last_mode;
                r = k_m / W;
                c = k_m % W;
                b.d = conv(s_data, offset_en);
                b.u = (k_m == 0);
                b.l = (c == W - 1) && (mode_m || r == H - 1);
                q.push_back(b);
                zero_m = 1'b0;
                k_m++;
                if (k_m == H * W) begin
                    k_m = 0;
                    fc_m++;
                end
            end
            rdy_m = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
        chk("m_valid", 32'(master_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_data", 32'(master_data_o), 32'(q[0].d));
            chk("m_user", 32'(master_user_o), 32'(q[0].u));
            chk("m_last", 32'(master_last_o), 32'(q[0].l));
        end else begin
            chk("m_user_idle", 32'(master_user_o), 32'd0);
            chk("m_last_idle", 32'(master_last_o), 32'd0);
            if (zero_m) chk("m_data_reset", 32'(master_data_o), 32'd0);
        end
        chk("s_ready", 32'(slave_ready_o), 32'(rdy_m));
        chk("frame_count", 32'(frame_count_o), 32'(fc_m));
        chk("resync", 32'(resync_o), 32'(res_m));
    endtask

    task automatic align();
        int guard;
        guard = 0;
        s_user = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        while (k_m != 0 && guard < 20) begin
            s_data = 24'($urandom);
            tick();
            guard++;
        end
        s_valid = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        mode;
        logic        ev;
        logic [23:0] ed;
        logic        eu;
        logic        el;
        logic [15:0] efc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [23:0] held;
        logic [15:0] fc_before;
        int          n_acc, last_at, guard;

        for (int i = 0; i < 6; i++)
            tbl[i] = '{1'b1, 24'h80FF00, 1'b0, 1'b1, 24'h007F80, i == 0, i == 5,
                       (i == 5) ? 16'd1 : 16'd0};
        tbl[6] = '{1'b0, 24'h000000, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 16'd1};
        for (int i = 0; i < 6; i++)
            tbl[7+i] = '{1'b1, 24'h010203, i < 3, 1'b1, 24'h818283, i == 0,
                         (i == 2) || (i == 5), (i == 5) ? 16'd2 : 16'd1};
        for (int i = 0; i < 6; i++)
            tbl[13+i] = '{1'b1, 24'hFF7F80, 1'b0, 1'b1, 24'h7FFF00, i == 0, i == 5,
                          (i == 5) ? 16'd3 : 16'd2};

        // Reset state
        reset_i = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(slave_ready_o), 32'd0);
        chk("rst_valid", 32'(master_valid_o), 32'd0);
        chk("rst_data", 32'(master_data_o), 32'd0);
        chk("rst_fc", 32'(frame_count_o), 32'd0);
        reset_i = 1'b0;
        tick();
        chk("ready_after_release", 32'(slave_ready_o), 32'd1);

        // Directed frames: EOF mode, EOL mode with mid-frame flip, EOF again
        offset_en = 1'b1;
        m_ready = 1'b1;
        s_user = 1'b0;
        for (int i = 0; i < 19; i++) begin
            s_valid = tbl[i].v;
            s_data = tbl[i].d;
            last_mode = tbl[i].mode;
            tick();
            chk("tbl_valid", 32'(master_valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_data", 32'(master_data_o), 32'(tbl[i].ed));
            chk("tbl_user", 32'(master_user_o), 32'(tbl[i].eu));
            chk("tbl_last", 32'(master_last_o), 32'(tbl[i].el));
            chk("tbl_fc", 32'(frame_count_o), 32'(tbl[i].efc));
        end
        s_valid = 1'b0;
        last_mode = 1'b0;
        tick();

        // Backpressure: downstream stalled for 5 cycles under continuous input
        align();
        m_ready = 1'b0;
        s_valid = 1'b1;
        n_acc = 0;
        held = 24'h000000;
        for (int i = 0; i < 5; i++) begin
            s_data = 24'($urandom);
            if (slave_ready_o) n_acc++;
            tick();
            if (i == 0) held = master_data_o;
            else chk("bp_hold", 32'(master_data_o), 32'(held));
        end
        chk("bp_accepts", 32'(n_acc), 32'd2);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Resync on the 4th beat of a frame
        align();
        last_mode = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 24'($urandom);
            tick();
        end
        fc_before = frame_count_o;
        s_user = 1'b1;
        s_data = 24'($urandom);
        tick();
        chk("resync_pulse", 32'(resync_o), 32'd1);
        chk("resync_user", 32'(master_user_o), 32'd1);
        chk("resync_fc", 32'(frame_count_o), 32'(fc_before + 16'd1));
        s_user = 1'b0;
        last_at = -1;
        for (int i = 1; i <= 5; i++) begin
            s_data = 24'($urandom);
            tick();
            if (i == 1) chk("resync_one_cycle", 32'(resync_o), 32'd0);
            if (master_last_o && last_at < 0) last_at = i;
        end
        chk("resync_next_eof", 32'(last_at), 32'd5);
        s_valid = 1'b0;
        tick();

        // Reset mid-frame with two beats buffered
        align();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = 24'($urandom);
            tick();
        end
        reset_i = 1'b1;
        tick();
        chk("midrst_valid", 32'(master_valid_o), 32'd0);
        chk("midrst_fc", 32'(frame_count_o), 32'd0);
        reset_i = 1'b0;
        s_valid = 1'b0;
        tick();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 24'($urandom);
        tick();
        chk("user_after_reset", 32'(master_user_o), 32'd1);
        s_valid = 1'b0;
        tick();

        // Frame counter wrap, reaching 0xFFFF quickly through back-to-back resyncs
        align();
        offset_en = 1'b1;
        s_user = 1'b1;
        s_valid = 1'b1;
        guard = 0;
        while (fc_m != 16'hFFFF && guard < 70000) begin
            s_data = 24'($urandom);
            tick();
            guard++;
        end
        chk("wrap_preload", 32'(frame_count_o), 32'h0000FFFF);
        s_user = 1'b0;
        offset_en = 1'b0;
        s_data = 24'h123456;
        tick();
        chk("passthrough", 32'(master_data_o), 32'h00123456);
        guard = 0;
        while (k_m != 0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("fc_wrap", 32'(frame_count_o), 32'd0);
        s_valid = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset_i   = ($urandom_range(0, 199) == 0);
            s_valid   = ($urandom_range(0, 3) != 0);
            s_user    = ($urandom_range(0, 15) == 0);
            m_ready   = ($urandom_range(0, 3) != 0);
            last_mode = 1'($urandom_range(0, 1));
            offset_en = 1'($urandom_range(0, 1));
            s_data    = 24'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
